// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The master side drives the operands and consumes results; the slave is the adder pipe.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op, cin, X, Y, out_ready,
        input  in_ready, out_valid, S, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op, cin, X, Y, out_ready,
        output in_ready, out_valid, S, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Carry-pipelined carry-lookahead adder/subtractor: one 16-bit lookahead block per stage.
// Optional macro CLA_PIPE_FLAGS_EN enables the registered ovf/zero flags (tied to 0 otherwise).
module cla_pipe_adder #(
    parameter int WIDTH = 32
) (
    input logic             clock,
    input logic             clear_n,
    cla_pipe_adder_if.slave bus
);
    localparam int NBLK = WIDTH / 16;

    // Two-level lookahead: bit P/G -> 4-bit group P/G -> group carries -> bit carries.
    // Returns {carry_out, sum[15:0]}.
    function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
        logic [15:0] p;
        logic [15:0] g;
        logic [3:0]  gp;
        logic [3:0]  gg;
        logic [4:0]  gc;
        logic [16:0] c;
        p = a ^ b;
        g = a & b;
        for (int j = 0; j < 4; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = ci;
        gc[1] = gg[0] | (gp[0] & ci);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & ci);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        c[16] = gc[4];
        return {c[16], p ^ c[15:0]};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] y_cond;
    logic             c0;

    logic             valid_reg [NBLK];
    logic             carry_reg [NBLK];
    logic [WIDTH-1:0] x_reg     [NBLK];
    logic [WIDTH-1:0] y_reg     [NBLK];
    logic [WIDTH-1:0] s_reg     [NBLK];

    // The whole pipe moves together; only a held result at the output stalls it.
    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;
    assign bus.out_valid = valid_reg[NBLK-1];
    assign bus.S        = s_reg[NBLK-1];
    assign bus.cout     = carry_reg[NBLK-1];

    assign y_cond = bus.op[0] ? ~bus.Y : bus.Y;
    assign c0     = bus.op[1] ? bus.cin : bus.op[0];

`ifdef CLA_PIPE_FLAGS_EN
    logic ovf_reg;
    logic zero_reg;
    logic ovf_next;
    logic zero_next;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_stage
            logic             v_in;
            logic             c_in;
            logic [WIDTH-1:0] x_in;
            logic [WIDTH-1:0] y_in;
            logic [WIDTH-1:0] s_in;
            logic [WIDTH-1:0] s_next;
            logic [16:0]      blk;

            if (gi == 0) begin : g_head
                assign v_in = bus.in_valid;
                assign c_in = c0;
                assign x_in = bus.X;
                assign y_in = y_cond;
                assign s_in = '0;
            end else begin : g_body
                assign v_in = valid_reg[gi-1];
                assign c_in = carry_reg[gi-1];
                assign x_in = x_reg[gi-1];
                assign y_in = y_reg[gi-1];
                assign s_in = s_reg[gi-1];
            end

            assign blk = cla16(x_in[16*gi +: 16], y_in[16*gi +: 16], c_in);

            // Lower slices pass through untouched; this stage fills in its own slice.
            always_comb begin
                s_next              = s_in;
                s_next[16*gi +: 16] = blk[15:0];
            end

            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    valid_reg[gi] <= 1'b0;
                    carry_reg[gi] <= 1'b0;
                    x_reg[gi]     <= '0;
                    y_reg[gi]     <= '0;
                    s_reg[gi]     <= '0;
                end else if (adv) begin
                    valid_reg[gi] <= v_in;
                    carry_reg[gi] <= blk[16];
                    x_reg[gi]     <= x_in;
                    y_reg[gi]     <= y_in;
                    s_reg[gi]     <= s_next;
                end
            end

`ifdef CLA_PIPE_FLAGS_EN
            if (gi == NBLK - 1) begin : g_flags
                // Carry into the MSB is recovered as s ^ a ^ b at that bit.
                assign ovf_next  = x_in[WIDTH-1] ^ y_in[WIDTH-1] ^ s_next[WIDTH-1] ^ blk[16];
                assign zero_next = (s_next == '0);
            end
`endif
        end
    endgenerate

`ifdef CLA_PIPE_FLAGS_EN
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else if (adv) begin
            ovf_reg  <= ovf_next;
            zero_reg <= zero_next;
        end
    end

    assign bus.ovf  = ovf_reg;
    assign bus.zero = zero_reg;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule
